// File: rtl/fwd_pkg.sv
// Shared constants, select-width helper and hazard-cause type for the
// forwarding / hazard scoreboard.
package fwd_pkg;

  localparam int SEL_RF = 0;

  function automatic int sel_w(input int num_fwd);
    return $clog2(num_fwd + 2);
  endfunction

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    LOAD_USE = 2'd1,
    PENDING  = 2'd2,
    WAW      = 2'd3
  } hazard_e;

endpackage

// File: rtl/fwd_src_select.sv
// Per-source operand select: youngest matching forwarding stage, then the
// completion bus, then the register file; flags load-use and pending hazards.
module fwd_src_select
  import fwd_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = sel_w(NUM_FWD)
) (
  input  logic [ADDR_W-1:0]              rs,
  input  logic                           rs_used,
  input  logic [NUM_FWD-1:0][ADDR_W-1:0] stg_rd,
  input  logic [NUM_FWD-1:0]             stg_regwrite,
  input  logic [NUM_FWD-1:0]             stg_ready,
  input  logic                           cpl_valid,
  input  logic [ADDR_W-1:0]              cpl_rd,
  input  logic                           rs_pending,
  output logic [SEL_W-1:0]               sel,
  output logic                           hazard
);

  logic hit;

  always_comb begin
    sel    = SEL_W'(SEL_RF);
    hazard = 1'b0;
    hit    = 1'b0;
    if (rs_used && rs != '0) begin
      // Scan oldest to youngest so the lowest matching stage is the last writer.
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (stg_regwrite[k] && stg_rd[k] == rs) begin
          hit    = 1'b1;
          hazard = ~stg_ready[k];
          sel    = stg_ready[k] ? SEL_W'(k + 1) : SEL_W'(SEL_RF);
        end
      end
      if (!hit) begin
        if (cpl_valid && cpl_rd == rs) begin
          sel = SEL_W'(NUM_FWD + 1);
        end else if (rs_pending) begin
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Decode-stage forwarding and hazard unit with a long-latency write scoreboard.
// Optional stall-cycle counter enabled by defining FWD_STALL_CNT_EN.
module fwd_hazard_scoreboard
  import fwd_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 32,
  localparam int SEL_W  = sel_w(NUM_FWD),
  localparam int NREG   = 2 ** ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           id_valid,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]             id_rs_used,
  input  logic [ADDR_W-1:0]              id_rd,
  input  logic                           id_regwrite,
  input  logic                           id_long,
  input  logic                           flush,
  input  logic [NUM_FWD-1:0][ADDR_W-1:0] stg_rd,
  input  logic [NUM_FWD-1:0]             stg_regwrite,
  input  logic [NUM_FWD-1:0]             stg_ready,
  input  logic                           cpl_valid,
  input  logic [ADDR_W-1:0]              cpl_rd,
  input  logic                           perf_clr,
  output logic [NUM_SRC-1:0][SEL_W-1:0]  fwd_sel,
  output logic                           stall,
  output logic [NREG-1:0]                pending,
  output logic [CNT_W-1:0]               stall_cnt
);

  logic [NREG-1:0]    pending_q, pending_d;
  logic [NREG-1:0]    eff_pending;
  logic [NUM_SRC-1:0] src_hazard;
  logic               waw_hazard;
  logic               issue;

  // A completion landing this cycle already satisfies readers of its register.
  always_comb begin
    eff_pending = pending_q;
    if (cpl_valid) eff_pending[cpl_rd] = 1'b0;
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_src_select #(
      .ADDR_W  (ADDR_W),
      .NUM_FWD (NUM_FWD),
      .SEL_W   (SEL_W)
    ) u_sel (
      .rs           (id_rs[s]),
      .rs_used      (id_rs_used[s]),
      .stg_rd       (stg_rd),
      .stg_regwrite (stg_regwrite),
      .stg_ready    (stg_ready),
      .cpl_valid    (cpl_valid),
      .cpl_rd       (cpl_rd),
      .rs_pending   (eff_pending[id_rs[s]]),
      .sel          (fwd_sel[s]),
      .hazard       (src_hazard[s])
    );
  end

  assign waw_hazard = id_regwrite && (id_rd != '0) && eff_pending[id_rd];
  assign stall      = id_valid && !flush && (|src_hazard || waw_hazard);
  assign issue      = id_valid && !flush && !stall && id_long && id_regwrite && (id_rd != '0);

  // Set is applied after clear so a new issue owns a register completing now.
  always_comb begin
    pending_d = pending_q;
    if (cpl_valid) pending_d[cpl_rd] = 1'b0;
    if (issue)     pending_d[id_rd]  = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending = pending_q;

`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (perf_clr)                         stall_cnt_d = '0;
    else if (stall && stall_cnt_q != '1)  stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign stall_cnt       = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural scoreboard model.
module tb_fwd_hazard_scoreboard;
  import fwd_pkg::*;

  localparam int ADDR_W  = 5;
  localparam int NUM_FWD = 2;
  localparam int NUM_SRC = 2;
  localparam int CNT_W   = 32;
  localparam int SEL_W   = $clog2(NUM_FWD + 2);
  localparam int NREG    = 2 ** ADDR_W;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic                           id_valid;
  logic [NUM_SRC-1:0][ADDR_W-1:0] id_rs;
  logic [NUM_SRC-1:0]             id_rs_used;
  logic [ADDR_W-1:0]              id_rd;
  logic                           id_regwrite;
  logic                           id_long;
  logic                           flush;
  logic [NUM_FWD-1:0][ADDR_W-1:0] stg_rd;
  logic [NUM_FWD-1:0]             stg_regwrite;
  logic [NUM_FWD-1:0]             stg_ready;
  logic                           cpl_valid;
  logic [ADDR_W-1:0]              cpl_rd;
  logic                           perf_clr;
  logic [NUM_SRC-1:0][SEL_W-1:0]  fwd_sel;
  logic                           stall;
  logic [NREG-1:0]                pending;
  logic [CNT_W-1:0]               stall_cnt;

  fwd_hazard_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_FWD (NUM_FWD),
    .NUM_SRC (NUM_SRC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rs_used   (id_rs_used),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_long      (id_long),
    .flush        (flush),
    .stg_rd       (stg_rd),
    .stg_regwrite (stg_regwrite),
    .stg_ready    (stg_ready),
    .cpl_valid    (cpl_valid),
    .cpl_rd       (cpl_rd),
    .perf_clr     (perf_clr),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .pending      (pending),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: which registers await a long-latency result, and stall count.
  bit [NREG-1:0]   m_pend;
  longint unsigned m_cnt;
  int              m_sel [NUM_SRC];
  hazard_e         m_cause [NUM_SRC];
  hazard_e         m_waw;
  bit              m_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_src(input int s);
    int r;
    r = int'(id_rs[s]);
    m_sel[s]   = 0;
    m_cause[s] = NONE;
    if (!id_rs_used[s] || r == 0) return;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (stg_regwrite[k] && int'(stg_rd[k]) == r) begin
        if (!stg_ready[k]) m_cause[s] = LOAD_USE;
        else               m_sel[s]   = k + 1;
        return;
      end
    end
    if (cpl_valid && int'(cpl_rd) == r) begin
      m_sel[s] = NUM_FWD + 1;
      return;
    end
    if (m_pend[r]) m_cause[s] = PENDING;
  endfunction

  function automatic void model_eval();
    bit any;
    any = 0;
    if (!rst_n) begin
      m_pend = '0;
      m_cnt  = 0;
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      ref_src(s);
      if (m_cause[s] != NONE) any = 1;
    end
    m_waw = (id_regwrite && id_rd != 0 && m_pend[id_rd] && !(cpl_valid && cpl_rd == id_rd)) ? WAW : NONE;
    m_stall = id_valid && !flush && (any || m_waw != NONE);
  endfunction

  task automatic settle_and_check();
    #1;
    model_eval();
    chk("stall", 64'(stall), 64'(m_stall));
    chk("pending", 64'(pending), 64'(m_pend));
    chk("stall_cnt", 64'(stall_cnt), m_cnt);
    for (int s = 0; s < NUM_SRC; s++)
      if (m_cause[s] == NONE) chk($sformatf("fwd_sel%0d", s), 64'(fwd_sel[s]), 64'(m_sel[s]));
  endtask

  task automatic tick();
    bit [NREG-1:0]   np;
    longint unsigned nc;
    model_eval();
    np = m_pend;
    nc = m_cnt;
    if (cpl_valid) np[cpl_rd] = 1'b0;
    if (id_valid && !flush && !m_stall && id_long && id_regwrite && id_rd != 0) np[id_rd] = 1'b1;
`ifdef FWD_STALL_CNT_EN
    if (perf_clr)                                   nc = 0;
    else if (m_stall && nc < 64'hFFFF_FFFF)         nc = nc + 1;
`else
    nc = 0;
`endif
    @(posedge clk);
    if (rst_n) begin
      m_pend = np;
      m_cnt  = nc;
    end else begin
      m_pend = '0;
      m_cnt  = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid     = 1'b0;
    id_rs        = '0;
    id_rs_used   = '0;
    id_rd        = '0;
    id_regwrite  = 1'b0;
    id_long      = 1'b0;
    flush        = 1'b0;
    stg_rd       = '0;
    stg_regwrite = '0;
    stg_ready    = '1;
    cpl_valid    = 1'b0;
    cpl_rd       = '0;
    perf_clr     = 1'b0;
  endtask

  task automatic issue_long(input logic [ADDR_W-1:0] rd);
    idle();
    id_valid = 1'b1; id_rd = rd; id_regwrite = 1'b1; id_long = 1'b1;
    settle_and_check();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    m_pend = '0;
    m_cnt  = 0;
    @(negedge clk);
    settle_and_check();
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_cnt", 64'(stall_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Youngest stage wins when both stages write the same register.
    idle();
    id_valid = 1'b1; id_rs[0] = 5'd5; id_rs_used[0] = 1'b1;
    stg_rd[0] = 5'd5; stg_rd[1] = 5'd5; stg_regwrite = 2'b11;
    settle_and_check();
    chk("youngest_sel", 64'(fwd_sel[0]), 64'd1);
    chk("youngest_stall", 64'(stall), 64'd0);
    tick();

    // Load-use on source 1, then resolved once the load returns.
    idle();
    id_valid = 1'b1; id_rs[1] = 5'd7; id_rs_used[1] = 1'b1;
    stg_rd[0] = 5'd7; stg_regwrite[0] = 1'b1; stg_ready[0] = 1'b0;
    settle_and_check();
    chk("load_use_stall", 64'(stall), 64'd1);
    tick();
    stg_ready[0] = 1'b1;
    settle_and_check();
    chk("load_ready_sel", 64'(fwd_sel[1]), 64'd1);
    chk("load_ready_stall", 64'(stall), 64'd0);
    tick();

    // Long op to r9: pending stall, then same-cycle completion bypass.
    issue_long(5'd9);
    idle();
    id_valid = 1'b1; id_rs[0] = 5'd9; id_rs_used[0] = 1'b1;
    settle_and_check();
    chk("pend_stall", 64'(stall), 64'd1);
    chk("pend_bit9", 64'(pending[9]), 64'd1);
    cpl_valid = 1'b1; cpl_rd = 5'd9;
    settle_and_check();
    chk("cpl_sel", 64'(fwd_sel[0]), 64'd3);
    chk("cpl_stall", 64'(stall), 64'd0);
    tick();
    idle();
    settle_and_check();
    chk("cpl_cleared", 64'(pending[9]), 64'd0);

    // Write-after-write against an outstanding long op.
    issue_long(5'd4);
    idle();
    id_valid = 1'b1; id_rd = 5'd4; id_regwrite = 1'b1;
    settle_and_check();
    chk("waw_stall", 64'(stall), 64'd1);
    cpl_valid = 1'b1; cpl_rd = 5'd4;
    settle_and_check();
    chk("waw_cpl_stall", 64'(stall), 64'd0);
    tick();

    // Register zero never forwards; flush suppresses stall and issue.
    idle();
    id_valid = 1'b1; id_rs_used[0] = 1'b1; stg_regwrite[0] = 1'b1;
    settle_and_check();
    chk("r0_sel", 64'(fwd_sel[0]), 64'd0);
    chk("r0_stall", 64'(stall), 64'd0);
    tick();
    issue_long(5'd6);
    idle();
    id_valid = 1'b1; flush = 1'b1; id_rs[0] = 5'd6; id_rs_used[0] = 1'b1;
    id_rd = 5'd10; id_regwrite = 1'b1; id_long = 1'b1;
    settle_and_check();
    chk("flush_stall", 64'(stall), 64'd0);
    tick();
    idle();
    settle_and_check();
    chk("flush_no_set", 64'(pending[10]), 64'd0);

    // Stall counter: clear, three stall cycles, clear, then async reset.
    idle();
    perf_clr = 1'b1;
    settle_and_check();
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      id_valid = 1'b1; id_rs[1] = 5'd6; id_rs_used[1] = 1'b1;
      settle_and_check();
      tick();
    end
    idle();
    settle_and_check();
`ifdef FWD_STALL_CNT_EN
    chk("cnt_three", 64'(stall_cnt), 64'd3);
`else
    chk("cnt_tied", 64'(stall_cnt), 64'd0);
`endif
    perf_clr = 1'b1;
    id_valid = 1'b1; id_rs[1] = 5'd6; id_rs_used[1] = 1'b1;
    settle_and_check();
    tick();
    idle();
    settle_and_check();
    chk("cnt_cleared", 64'(stall_cnt), 64'd0);
    id_valid = 1'b1; id_rs[1] = 5'd6; id_rs_used[1] = 1'b1;
    settle_and_check();
    tick();
    rst_n = 1'b0;
    settle_and_check();
    chk("midrst_pending", 64'(pending), 64'd0);
    chk("midrst_cnt", 64'(stall_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    idle();
    tick();

    // Randomized traffic over a small register window to force collisions.
    for (int n = 0; n < 600; n++) begin
      rst_n        = ($urandom_range(0, 149) != 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < NUM_SRC; s++) begin
        id_rs[s]      = ADDR_W'($urandom_range(0, 7));
        id_rs_used[s] = 1'($urandom_range(0, 1));
      end
      id_rd        = ADDR_W'($urandom_range(0, 7));
      id_regwrite  = 1'($urandom_range(0, 1));
      id_long      = ($urandom_range(0, 2) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < NUM_FWD; k++) begin
        stg_rd[k]       = ADDR_W'($urandom_range(0, 7));
        stg_regwrite[k] = 1'($urandom_range(0, 1));
        stg_ready[k]    = ($urandom_range(0, 3) != 0);
      end
      cpl_valid    = ($urandom_range(0, 2) == 0);
      cpl_rd       = ADDR_W'($urandom_range(0, 7));
      perf_clr     = ($urandom_range(0, 19) == 0);
      settle_and_check();
      chk("cause_vs_stall", 64'(stall),
          64'(id_valid && !flush &&
              (m_cause[0] != NONE || m_cause[1] != NONE || m_waw != NONE)));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
